// File: rtl/noc_rr_merge_pkg.sv
// noc_pkg: shared flit types for the router merge/arbitration blocks.
//   FLIT_W          flit width; address nibble lives in [ADDR_HI:ADDR_LO]
//   IDX_W           index field width, wide enough for up to 8 merge inputs
//   flit_t          one flit
//   merge_entry_t   {idx, flit} as held in the merge output buffer
package noc_pkg;

    localparam int unsigned FLIT_W  = 9;
    localparam int unsigned ADDR_HI = 8;
    localparam int unsigned ADDR_LO = 5;
    localparam int unsigned IDX_W   = 3;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        flit_t            flit;
    } merge_entry_t;

endpackage

// File: rtl/noc_rr_merge_if.sv
// noc_rr_merge_if: handshake bundle of the round-robin merge.
//   in_valid/in_data/in_ready   NUM_IN request channels, flit i at [i*W +: W]
//   out_valid/out_data/out_ready merged flit channel
//   sel_valid/sel_data/sel_ready winner-index channel
// Modports: master = merge block, slave = its environment.
interface noc_rr_merge_if
    import noc_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned W      = FLIT_W
);
    localparam int unsigned IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN-1:0]   in_valid;
    logic [NUM_IN*W-1:0] in_data;
    logic [NUM_IN-1:0]   in_ready;
    logic                out_valid;
    logic [W-1:0]        out_data;
    logic                out_ready;
    logic                sel_valid;
    logic [IW-1:0]       sel_data;
    logic                sel_ready;

    modport master (
        input  in_valid, in_data, out_ready, sel_ready,
        output in_ready, out_valid, out_data, sel_valid, sel_data
    );

    modport slave (
        output in_valid, in_data, out_ready, sel_ready,
        input  in_ready, out_valid, out_data, sel_valid, sel_data
    );

endinterface

// File: rtl/noc_rr_merge_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    request vector
//   ptr    highest-priority position; scan runs ptr, ptr+1, ... mod N
//   grant  one-hot grant (zero when no request)
//   idx    index of the granted request
//   any    a request was granted
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic [IW:0]   pos;
        logic [IW-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            cand = pos[IW-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/noc_rr_merge.sv
// noc_rr_merge: round-robin merge of NUM_IN flit streams into one output,
// with a 2-entry {idx, flit} buffer and a separate winner-index channel.
//   CLK, RESET  clock, synchronous active-high reset
//   bus         noc_rr_merge_if.master (inputs, out channel, sel channel)
//   grant_cnt   per-input 8-bit saturating grant counters, present only
//               when NOC_RR_MERGE_ARB_STATS_EN is defined
module noc_rr_merge
    import noc_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned W      = FLIT_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    noc_rr_merge_if.master    bus
`ifdef NOC_RR_MERGE_ARB_STATS_EN
    ,
    output logic [NUM_IN*8-1:0] grant_cnt
`endif
);

    localparam int unsigned IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    if (W != FLIT_W || DEPTH != 2 || NUM_IN < 2 || NUM_IN > 8) begin : g_bad_cfg
        $error("noc_rr_merge: unsupported W/DEPTH/NUM_IN");
    end

    merge_entry_t      buf_q [2];
    merge_entry_t      head;
    logic              rd_ptr, wr_ptr;
    logic [1:0]        cnt;
    logic              out_sent, sel_sent;
    logic [IW-1:0]     rr_ptr;

    logic              has_head, out_fire, sel_fire, pop, can_push, push;
    logic [NUM_IN-1:0] pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    flit_t             in_flit;

    assign head     = buf_q[rd_ptr];
    assign has_head = (cnt != 2'd0);

    assign bus.out_valid = has_head && !out_sent;
    assign bus.sel_valid = has_head && !sel_sent;
    assign bus.out_data  = head.flit;
    assign bus.sel_data  = head.idx[IW-1:0];

    assign out_fire = bus.out_valid && bus.out_ready;
    assign sel_fire = bus.sel_valid && bus.sel_ready;

    // Head leaves once both channels are done, counting completions this cycle.
    assign pop      = has_head && (out_sent || out_fire) && (sel_sent || sel_fire);
    assign can_push = (cnt != 2'd2) || pop;

    rr_pick #(
        .N  (NUM_IN),
        .IW (IW)
    ) u_pick (
        .req   (bus.in_valid & {NUM_IN{can_push}}),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // RESET blocks any handshake in the cycle it is sampled.
    assign bus.in_ready = RESET ? '0 : pick_grant;
    assign push         = pick_any && !RESET;

    always_comb begin
        in_flit = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (pick_grant[i]) begin
                in_flit = bus.in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            cnt      <= 2'd0;
            out_sent <= 1'b0;
            sel_sent <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= '{idx: IDX_W'(pick_idx), flit: in_flit};
                wr_ptr        <= ~wr_ptr;
                rr_ptr        <= (pick_idx == IW'(NUM_IN-1)) ? '0 : pick_idx + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                out_sent <= 1'b0;
                sel_sent <= 1'b0;
            end else begin
                if (out_fire) out_sent <= 1'b1;
                if (sel_fire) sel_sent <= 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef NOC_RR_MERGE_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            grant_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (pick_grant[i] && grant_cnt[i*8 +: 8] != 8'hFF) begin
                    grant_cnt[i*8 +: 8] <= grant_cnt[i*8 +: 8] + 8'd1;
                end
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // Offered flits must stay valid and unchanged until accepted.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_hold_chk
        a_in_hold: assert property (@(posedge CLK) disable iff (RESET)
            (bus.in_valid[g] && !bus.in_ready[g]) |=>
            (bus.in_valid[g] && $stable(bus.in_data[g*W +: W])));
    end
`endif

endmodule

// File: tb/tb_noc_rr_merge.sv
// tb_noc_rr_merge: directed scenarios plus randomized traffic for
// noc_rr_merge, checked every cycle against a queue-based reference model.
// Build with NOC_RR_MERGE_ARB_STATS_EN to also exercise grant_cnt.
module tb_noc_rr_merge;
    import noc_pkg::*;

    localparam int unsigned NUM_IN = 4;
    localparam int unsigned W      = 9;
    localparam int unsigned IW     = 2;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    noc_rr_merge_if #(.NUM_IN(NUM_IN), .W(W)) bus ();

`ifdef NOC_RR_MERGE_ARB_STATS_EN
    logic [NUM_IN*8-1:0] grant_cnt;
`endif

    noc_rr_merge #(
        .NUM_IN (NUM_IN),
        .W      (W),
        .DEPTH  (2)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
`ifdef NOC_RR_MERGE_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    typedef struct {
        int unsigned idx;
        int unsigned data;
    } ent_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: buffered flits in arrival order, per-channel done
    // flags for the head, and the input that gets first look next time.
    ent_t        mq[$];
    bit          m_osent, m_ssent;
    int unsigned m_ptr;

    // Input refill policy after a grant: 0 drop, 1 random, 2 re-offer.
    int unsigned mode;

    logic [NUM_IN-1:0] obs_rdy;
    logic              obs_ov, obs_sv;
    logic [W-1:0]      obs_od;
    logic [IW-1:0]     obs_sd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit                ov, sv, pop, room, has_win;
        int unsigned       win, j;
        logic [NUM_IN-1:0] er;
        logic [W-1:0]      d;
        #1;
        obs_rdy = bus.in_ready;
        obs_ov  = bus.out_valid;
        obs_sv  = bus.sel_valid;
        obs_od  = bus.out_data;
        obs_sd  = bus.sel_data;

        ov   = (mq.size() > 0) && !m_osent;
        sv   = (mq.size() > 0) && !m_ssent;
        pop  = (mq.size() > 0) && (m_osent || (ov && bus.out_ready))
                               && (m_ssent || (sv && bus.sel_ready));
        room = (mq.size() < 2) || pop;
        has_win = 1'b0;
        win     = 0;
        er      = '0;
        if (room && !RESET) begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                j = (m_ptr + k) % NUM_IN;
                if (!has_win && bus.in_valid[j]) begin
                    has_win = 1'b1;
                    win     = j;
                end
            end
        end
        if (has_win) er[win] = 1'b1;

        check_eq("in_ready", 32'(obs_rdy), 32'(er));
        check_eq("out_valid", 32'(obs_ov), 32'(ov));
        check_eq("sel_valid", 32'(obs_sv), 32'(sv));
        if (ov) check_eq("out_data", 32'(obs_od), mq[0].data);
        if (sv) check_eq("sel_data", 32'(obs_sd), mq[0].idx);

        if (RESET) begin
            mq.delete();
            m_osent = 1'b0;
            m_ssent = 1'b0;
            m_ptr   = 0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_osent = 1'b0;
                m_ssent = 1'b0;
            end else begin
                if (ov && bus.out_ready) m_osent = 1'b1;
                if (sv && bus.sel_ready) m_ssent = 1'b1;
            end
            if (has_win) begin
                d = bus.in_data[win*W +: W];
                mq.push_back('{idx: win, data: 32'(d)});
                m_ptr = (win + 1) % NUM_IN;
            end
        end

        @(posedge CLK);
        @(negedge CLK);

        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (obs_rdy[i]) begin
                if (mode == 0) begin
                    bus.in_valid[i] = 1'b0;
                end else begin
                    bus.in_valid[i]      = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                    bus.in_data[i*W +: W] = W'($urandom);
                end
            end else if (mode == 1 && !bus.in_valid[i]) begin
                bus.in_valid[i]      = ($urandom_range(0, 2) == 0);
                bus.in_data[i*W +: W] = W'($urandom);
            end
        end
    endtask

    logic [W-1:0] t1d [4];
    logic [W-1:0] t3d;

    initial begin
        t1d[0] = 9'h1A0; t1d[1] = 9'h0B1; t1d[2] = 9'h1C2; t1d[3] = 9'h0D3;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.sel_ready = 1'b0;
        mode    = 0;
        m_osent = 1'b0;
        m_ssent = 1'b0;
        m_ptr   = 0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        step();
        check_eq("rst_out_data", 32'(obs_od), 32'h0);
        check_eq("rst_sel_data", 32'(obs_sd), 32'h0);
        RESET = 1'b0;

        // All four inputs, one flit each, consumers always ready.
        bus.out_ready = 1'b1;
        bus.sel_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_data   = {t1d[3], t1d[2], t1d[1], t1d[0]};
        step();
        check_eq("t1_first_grant", 32'(obs_rdy), 32'h1);
        for (int unsigned k = 0; k < 4; k++) begin
            step();
            check_eq("t1_out_valid", 32'(obs_ov), 32'h1);
            check_eq("t1_out_data", 32'(obs_od), 32'(t1d[k]));
            check_eq("t1_sel_data", 32'(obs_sd), k);
        end

        // Single requester on input 2.
        bus.in_valid = 4'b0100;
        bus.in_data[2*W +: W] = 9'h155;
        step();
        check_eq("t2_in_ready", 32'(obs_rdy), 32'h4);
        step();
        check_eq("t2_out_data", 32'(obs_od), 32'h155);
        check_eq("t2_sel_data", 32'(obs_sd), 32'h2);

        // Fill the buffer, then drain one entry while input 2 slips in.
        bus.out_ready = 1'b0;
        bus.sel_ready = 1'b0;
        bus.in_valid  = 4'b0111;
        bus.in_data   = {W'(0), W'($urandom), W'($urandom), W'($urandom)};
        t3d = bus.in_data[0 +: W];
        step();
        check_eq("t3_grant0", 32'(obs_rdy), 32'h1);
        step();
        check_eq("t3_grant1", 32'(obs_rdy), 32'h2);
        step();
        check_eq("t3_full_block", 32'(obs_rdy), 32'h0);
        bus.out_ready = 1'b1;
        bus.sel_ready = 1'b1;
        step();
        check_eq("t3_passthru", 32'(obs_rdy), 32'h4);
        check_eq("t3_head_data", 32'(obs_od), 32'(t3d));
        repeat (3) step();

        // Index accepted early; data channel stalled for three cycles.
        bus.out_ready = 1'b0;
        bus.sel_ready = 1'b1;
        bus.in_valid  = 4'b1001;
        bus.in_data   = {W'($urandom), W'(0), W'(0), W'($urandom)};
        step();
        step();
        check_eq("t4_sel_first", 32'(obs_sv), 32'h1);
        step();
        check_eq("t4_sel_drop", 32'(obs_sv), 32'h0);
        check_eq("t4_out_hold", 32'(obs_ov), 32'h1);
        step();
        check_eq("t4_sel_low", 32'(obs_sv), 32'h0);
        bus.out_ready = 1'b1;
        step();
        check_eq("t4_pop_valid", 32'(obs_ov), 32'h1);
        step();
        check_eq("t4_next_sv", 32'(obs_sv), 32'h1);
        check_eq("t4_next_idx", 32'(obs_sd), 32'h0);
        repeat (2) step();

        // Reset with two flits buffered.
        bus.out_ready = 1'b0;
        bus.sel_ready = 1'b0;
        bus.in_valid  = 4'b0011;
        bus.in_data   = {W'(0), W'(0), W'($urandom), W'($urandom)};
        step();
        step();
        RESET = 1'b1;
        step();
        check_eq("t5_rst_block", 32'(obs_rdy), 32'h0);
        RESET = 1'b0;
        bus.in_valid = 4'b1111;
        bus.in_data  = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
        step();
        check_eq("t5_ov_cleared", 32'(obs_ov), 32'h0);
        check_eq("t5_sv_cleared", 32'(obs_sv), 32'h0);
        check_eq("t5_grant0", 32'(obs_rdy), 32'h1);
        bus.out_ready = 1'b1;
        bus.sel_ready = 1'b1;
        repeat (8) step();

        // Random traffic and random back-pressure on both channels.
        mode = 1;
        repeat (3000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.sel_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        mode = 0;
        bus.out_ready = 1'b1;
        bus.sel_ready = 1'b1;
        repeat (20) step();
        check_eq("drain_empty", 32'(obs_ov), 32'h0);

`ifdef NOC_RR_MERGE_ARB_STATS_EN
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        mode = 2;
        bus.in_valid = 4'b0010;
        bus.in_data[W +: W] = W'($urandom);
        repeat (300) step();
        bus.in_valid = '0;
        mode = 0;
        step();
        check_eq("cnt0", 32'(grant_cnt[7:0]), 32'h0);
        check_eq("cnt1_sat", 32'(grant_cnt[15:8]), 32'hFF);
        check_eq("cnt2", 32'(grant_cnt[23:16]), 32'h0);
        check_eq("cnt3", 32'(grant_cnt[31:24]), 32'h0);
        repeat (4) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noc_rr_merge.md
Name: noc_rr_merge

Overview:
- Round-robin arbiter that merges NUM_IN flit streams into a single output channel; the inverse of the address decoder tree.
- Sits at each router output port, collecting decoder Out0/Out1 branches that target the same port.
- A two-entry output buffer decouples arbitration from downstream stalls.
- Emits the winning input index on a separate Sel channel, mirroring the decoder's S token, so downstream logic can trace the route.

Parameters:
- NUM_IN, 4, number of requesting inputs (2..8).
- W, 9, flit width; bits [8:5] are the address nibble, passed through untouched.
- DEPTH, 2, output buffer entries (fixed to 2; any other value is illegal).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  NUM_IN  per-input flit offered.
- in_data  in  NUM_IN*W  packed flits; input i occupies [i*W +: W].
- in_ready  out  NUM_IN  per-input accept; one-hot or zero.
- out_valid  out  1  flit available.
- out_data  out  W  flit.
- out_ready  in  1  consumer accepts flit.
- sel_valid  out  1  winner index available.
- sel_data  out  $clog2(NUM_IN)  index of the input that supplied the head flit.
- sel_ready  in  1  consumer accepts index.
- Optional: grant_cnt  out  NUM_IN*8  (only with ARB_STATS_EN).

Behaviour:
- Reset, sampled on the CLK edge while RESET=1:
  - rr_ptr=0, buffer count=0, both sent flags=0.
  - Outputs: in_ready=0, out_valid=0, sel_valid=0, out_data=0, sel_data=0.
  - RESET asserted mid-transfer discards buffered flits; no partial handshake completes in that cycle.
- Buffer: 2-entry circular FIFO of {idx, data}; rd_ptr/wr_ptr are 1 bit; count is 0..2.
- Head entry delivery:
  - out_valid = sel_valid = (count>0) && !sent flag of that channel.
  - Each channel completes independently on valid&&ready and then sets its sent flag.
  - The head pops in the cycle in which the second channel completes. Both completing in the same cycle is a pop.
  - Pop clears both flags.
- Space: can_push = (count<2) || pop_this_cycle. Pop is combinational from the ready inputs, so a full buffer accepts a new flit in the same cycle it drains.
- Arbitration (combinational):
  - If can_push, scan inputs rr_ptr, rr_ptr+1, … mod NUM_IN.
  - The first i with in_valid[i] wins; in_ready[i]=1 for the winner only.
  - No valid input, or !can_push: in_ready=0.
- Update on a grant:
  - Push {i, in_data[i]}.
  - rr_ptr <= (i+1) mod NUM_IN.
  - With no grant, rr_ptr holds.
- Latency: a flit accepted in cycle t appears on out_valid/sel_valid in cycle t+1. There is no combinational in→out path.
- Throughput: 1 flit/cycle with both consumers always ready.
- Fairness: with all inputs valid, grants cycle 0,1,…,NUM_IN-1. Each continuously requesting input waits at most NUM_IN-1 grants.
- Flit content: order is FIFO; flits are never modified or dropped.
- Count update:
  - Simultaneous push and pop leaves count unchanged.
  - Pop at count=1 with no push → count=0, and valids drop next cycle.
- Input protocol: in_valid/in_data must be held until in_ready. This is asserted in simulation only.

Optional Feature:
- Macro: NOC_RR_MERGE_ARB_STATS_EN.
- Defined:
  - Adds grant_cnt: one 8-bit saturating counter per input, incremented on each grant to that input.
  - Holds at 255 once reached.
  - Cleared by RESET.
- Undefined:
  - Port and counters are absent.
  - All other behaviour is identical.

Decomposition:
- Package noc_pkg:
  - FLIT_W=9, ADDR_HI=8, ADDR_LO=5.
  - typedef flit_t.
  - typedef merge_entry_t {idx, flit}.
- Sub-module rr_pick: pure combinational.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Reusable by other arbiters in the router.

Test Plan:
- Reset, then in_valid=4'b1111 with data 0x1A0/0x0B1/0x1C2/0x0D3; both readys held 1 → outputs 0x1A0,0x0B1,0x1C2,0x0D3 on consecutive cycles, sel 0,1,2,3, rr_ptr wraps to 0.
- Only input 2 valid (0x155), ready=1 → in_ready=4'b0100; output 0x155, sel=2 one cycle later; rr_ptr=3.
- out_ready=0, sel_ready=0 with inputs 0,1 valid → two flits buffered, then in_ready=0. Release both readys in the same cycle → one pop; in the same cycle input 2 is granted (full-buffer pass-through); no loss.
- sel_ready=1 while out_ready=0 for 3 cycles → sel_valid drops after 1 cycle, out_valid stays with head data; entry pops when out_ready rises; the next index appears the following cycle.
- RESET=1 for 1 cycle with 2 flits buffered → next cycle out_valid=0, sel_valid=0; first post-reset grant goes to input 0.
- With NOC_RR_MERGE_ARB_STATS_EN: 300 grants to input 1 only → grant_cnt[1]=255, others 0.
